adder_share_sched: RTL and testbench
====================================

// Module: adder_share_sched
// PURPOSE
//  Round-robin scheduler that shares one 16-bit adder_2x8 instance among NREQ requesters.
//  Supports multi-word (chained) additions: carry-out of each word feeds carry-in of the next.
//  Sits in the FIR datapath between the tap/accumulate requesters and the single adder_2x8 instance.
// PARAMETERS
//  NREQ  4  number of requesters (2..2**IDW)
//  IDW   2  width of requester id fields
// PORTS
//  CLK        in   1        single clock, all logic rising-edge
//  RST        in   1        synchronous, active-high reset
//  req_valid  in   NREQ     per-requester word valid
//  req_a      in   NREQ*16  operand A, requester i at [16*i+15:16*i]
//  req_b      in   NREQ*16  operand B, same packing
//  req_cin    in   NREQ     carry-in; used on the first word of a chain only
//  req_last   in   NREQ     1 = final word of this requester's chain
//  req_ready  out  NREQ     one-hot accept; word transfers when req_valid[i] & req_ready[i]
//  add_a      out  16       to adder_2x8 .a
//  add_b      out  16       to adder_2x8 .b
//  add_cin    out  1        to adder_2x8 .cin
//  add_s      in   16       from adder_2x8 .s
//  add_cout   in   1        from adder_2x8 .cout
//  rsp_valid  out  1        result valid, held until rsp_ready
//  rsp_id     out  IDW      requester that owns the result
//  rsp_sum    out  16       add_s captured
//  rsp_cout   out  1        add_cout captured
//  rsp_last   out  1        copy of the accepted word's req_last
//  rsp_ready  in   1        result consumer accept
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, lock=0, carry_q=0; req_ready=0, rsp_valid=0, rsp_id=0,
//   rsp_sum=0, rsp_cout=0, rsp_last=0, add_a/add_b/add_cin=0.
//  FSM states: IDLE, LOCK, EXEC, RESP.
//  IDLE: winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NREQ.
//   req_ready is combinational, one-hot on the winner; all zero if no req_valid.
//   On transfer: op_a, op_b, id, last <= winner's word; op_cin <= req_cin[winner]; go to EXEC.
//  LOCK: entered after a non-last word completes. req_ready = one-hot on the locked id only.
//   Other requesters are starved until the chain ends. On transfer: op_cin <= carry_q and
//   req_cin is ignored; go to EXEC.
//  EXEC: one cycle. add_a/add_b/add_cin are driven from op registers; they are 0 in all other states.
//   At the clock edge: rsp_sum <= add_s, rsp_cout <= add_cout, carry_q <= add_cout,
//   rsp_id <= id, rsp_last <= last. Go to RESP.
//  RESP: rsp_valid=1. rsp_* stay stable while rsp_ready=0. No new word is accepted.
//   On rsp_ready: if last, go to IDLE, rr_ptr <= id+1 (wrap at NREQ), lock=0.
//   If not last, go to LOCK, lock=1.
//  Latency: transfer edge T, EXEC during T+1, rsp_valid from T+2.
//   Peak throughput is 1 word per 3 cycles.
//  rsp_valid and rsp_ready can rise in the same cycle. The response is then consumed in that cycle.
//  The adder is combinational and has no internal width growth: the 17-bit result is {cout,sum}.
//  req_valid dropping without a transfer is legal and has no effect.
//   Words are taken only on valid&ready.
//  rr_ptr does not advance on non-last words, so a chain holds priority.
//  RST in any state, including mid-chain, returns to the reset values.
//   The lock is released and carry_q is cleared. A partially transferred chain is discarded.
//  NREQ not a power of two: rr_ptr wraps from NREQ-1 to 0.
// TESTING
//  1 req0 a=00FF b=0001 cin=0 last=1 -> rsp_valid at T+2, id=0 sum=0100 cout=0 last=1.
//  2 req3 a=FFFF b=0001 cin=1 last=1 -> sum=0001 cout=1 id=3.
//  3 chain req2 (FFFF,0001,cin0,last0) then (0000,0000,cin1,last1),
//    req1 valid throughout -> rsp sum=0000 cout=1; then sum=0001 cout=0 (cin1 ignored);
//    req1 not granted until the chain ends.
//  4 all four req_valid held high, last=1, rsp_ready=1 -> grant order 0,1,2,3,0,1,
//    one transfer every 3 cycles.
//  5 rsp_ready low 5 cycles in RESP -> rsp_* stable, req_ready=0 for all, then released.
//  6 RST pulse during LOCK after first chain word -> all outputs 0.
//    Next req1 word is granted from IDLE with its own cin.

Source files
------------

// File: rtl/adder_share_sched.sv
// Round-robin scheduler sharing one 16-bit adder among NREQ requesters,
// with chained multi-word additions that carry between words.
module adder_share_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*16-1:0] req_a,
    input  logic [NREQ*16-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [15:0]       add_a,
    output logic [15:0]       add_b,
    output logic              add_cin,
    input  logic [15:0]       add_s,
    input  logic              add_cout,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       rsp_sum,
    output logic              rsp_cout,
    output logic              rsp_last,
    input  logic              rsp_ready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOCK = 2'd1;
    localparam logic [1:0] EXEC = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic           lock;
    logic           carry_q;
    logic [15:0]    op_a;
    logic [15:0]    op_b;
    logic           op_cin;
    logic [IDW-1:0] id;
    logic           last;

    logic           win_found;
    logic [IDW-1:0] win_id;
    logic [IDW-1:0] sel;
    logic           xfer;

    // Scan downward so the candidate closest to rr_ptr is assigned last and wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int j;
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (req_valid[j]) begin
                win_found = 1'b1;
                win_id    = IDW'(j);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!RST) begin
            case (state)
                IDLE: if (win_found) req_ready[win_id] = 1'b1;
                LOCK: if (lock) req_ready[id] = 1'b1;
                default: req_ready = '0;
            endcase
        end
    end

    assign sel       = (state == IDLE) ? win_id : id;
    assign xfer      = |(req_valid & req_ready);
    assign rsp_valid = (state == RESP);
    assign add_a     = (state == EXEC) ? op_a : 16'd0;
    assign add_b     = (state == EXEC) ? op_b : 16'd0;
    assign add_cin   = (state == EXEC) ? op_cin : 1'b0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            lock     <= 1'b0;
            carry_q  <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_cin   <= 1'b0;
            id       <= '0;
            last     <= 1'b0;
            rsp_id   <= '0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_last <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        op_a   <= req_a[int'(sel)*16 +: 16];
                        op_b   <= req_b[int'(sel)*16 +: 16];
                        op_cin <= req_cin[sel];
                        id     <= sel;
                        last   <= req_last[sel];
                        state  <= EXEC;
                    end
                end
                LOCK: begin
                    // Continuation words take the carry of the previous word.
                    if (xfer) begin
                        op_a   <= req_a[int'(sel)*16 +: 16];
                        op_b   <= req_b[int'(sel)*16 +: 16];
                        op_cin <= carry_q;
                        last   <= req_last[sel];
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_sum  <= add_s;
                    rsp_cout <= add_cout;
                    carry_q  <= add_cout;
                    rsp_id   <= id;
                    rsp_last <= last;
                    state    <= RESP;
                end
                default: begin
                    if (rsp_ready) begin
                        if (last) begin
                            state  <= IDLE;
                            lock   <= 1'b0;
                            rr_ptr <= (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
                        end else begin
                            state <= LOCK;
                            lock  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_sched.sv
// Directed bench for adder_share_sched with a behavioural adder on the
// shared adder port.
module tb_adder_share_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_cin;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_s;
    logic        add_cout;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_sum;
    logic        rsp_cout;
    logic        rsp_last;
    logic        rsp_ready;

    int checks = 0;
    int failures = 0;

    logic [16:0] full;
    assign full     = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
    assign add_s    = full[15:0];
    assign add_cout = full[16];

    adder_share_sched #(.NREQ(4), .IDW(2)) dut (
        .CLK(clk), .RST(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_cin(req_cin), .req_last(req_last), .req_ready(req_ready),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_cout(rsp_cout), .rsp_last(rsp_last), .rsp_ready(rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] es;
        logic        ec;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_rsp_sum"}, rsp_sum, 0);
        chk({tag, "_rsp_cout"}, rsp_cout, 0);
        chk({tag, "_rsp_last"}, rsp_last, 0);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_add"}, {add_cin, add_a, add_b}, 0);
    endtask

    // Called at a negedge; ends at the negedge after the response is consumed.
    task automatic send_word(input int i, input logic [15:0] a, input logic [15:0] b,
                             input logic cin, input logic lst, input logic [3:0] mask,
                             input logic ecin, input logic [15:0] es, input logic ec);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
        req_cin[i]  = cin;
        req_last[i] = lst;
        req_valid[i] = 1'b1;
        #1 chk("grant", req_ready, mask);
        @(negedge clk);
        req_valid[i] = 1'b0;
        chk("exec_rsp_valid", rsp_valid, 0);
        chk("exec_ready", req_ready, 0);
        chk("exec_add_a", add_a, a);
        chk("exec_add_b", add_b, b);
        chk("exec_add_cin", add_cin, ecin);
        @(negedge clk);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, i);
        chk("rsp_sum", rsp_sum, es);
        chk("rsp_cout", rsp_cout, ec);
        chk("rsp_last", rsp_last, lst);
        chk("resp_ready_zero", req_ready, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_consumed", rsp_valid, 0);
    endtask

    initial begin
        vec_t tbl[4];
        int n;
        int m;
        int gid;
        tbl[0] = '{id: 0, a: 16'h00FF, b: 16'h0001, cin: 1'b0, es: 16'h0100, ec: 1'b0};
        tbl[1] = '{id: 3, a: 16'hFFFF, b: 16'h0001, cin: 1'b1, es: 16'h0001, ec: 1'b1};
        tbl[2] = '{id: 2, a: 16'h8000, b: 16'h8000, cin: 1'b0, es: 16'h0000, ec: 1'b1};
        tbl[3] = '{id: 1, a: 16'h1234, b: 16'h4321, cin: 1'b1, es: 16'h5556, ec: 1'b0};

        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_cin = '0;
        req_last = '0;
        rsp_ready = 1'b0;
        do_reset();
        #1 chk_zero("reset");

        // Single-word transactions; leaves rr_ptr at 2.
        for (int k = 0; k < 4; k++) begin
            logic [3:0] mk;
            mk = '0;
            mk[tbl[k].id] = 1'b1;
            send_word(tbl[k].id, tbl[k].a, tbl[k].b, tbl[k].cin, 1'b1, mk,
                      tbl[k].cin, tbl[k].es, tbl[k].ec);
        end

        // Chain on req2 while req1 waits.
        req_a[31:16] = 16'h0005;
        req_b[31:16] = 16'h0003;
        req_cin[1] = 1'b0;
        req_last[1] = 1'b1;
        req_valid[1] = 1'b1;
        send_word(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'b0100, 1'b0, 16'h0000, 1'b1);
        send_word(2, 16'h0000, 16'h0000, 1'b1, 1'b1, 4'b0100, 1'b1, 16'h0001, 1'b0);
        req_valid[1] = 1'b0;
        send_word(1, 16'h0005, 16'h0003, 1'b0, 1'b1, 4'b0010, 1'b0, 16'h0008, 1'b0);

        // Second chain: continuation carry must come from carry_q, not req_cin.
        send_word(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'b0001, 1'b0, 16'h0000, 1'b1);
        send_word(0, 16'h0010, 16'h0020, 1'b0, 1'b1, 4'b0001, 1'b1, 16'h0031, 1'b0);

        // Round robin with every requester valid.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[16*i +: 16] = 16'h1000 * 16'(i + 1);
            req_b[16*i +: 16] = 16'h0001;
        end
        req_cin = '0;
        req_last = 4'b1111;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        n = 0;
        m = 0;
        for (int cyc = 0; cyc < 18; cyc++) begin
            #1;
            if (|(req_valid & req_ready)) begin
                gid = 0;
                for (int q = 0; q < 4; q++) if (req_ready[q]) gid = q;
                chk("rr_grant_id", gid, n % 4);
                chk("rr_grant_cycle", cyc, 3 * n);
                n++;
            end
            if (rsp_valid) begin
                chk("rr_rsp_id", rsp_id, m % 4);
                chk("rr_rsp_sum", rsp_sum, 16'h1000 * 16'((m % 4) + 1) + 16'h0001);
                m++;
            end
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        chk("rr_grants", n, 6);
        chk("rr_responses", m, 6);

        // Backpressure in RESP.
        do_reset();
        req_a[15:0] = 16'h0011;
        req_b[15:0] = 16'h0022;
        req_cin = '0;
        req_last = 4'b1111;
        req_valid = 4'b1001;
        #1 chk("bp_grant", req_ready, 4'b0001);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        for (int w = 0; w < 5; w++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_sum", rsp_sum, 16'h0033);
            chk("bp_id", rsp_id, 0);
            chk("bp_ready", req_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1 chk("bp_next_grant", req_ready, 4'b1000);
        req_valid = '0;
        @(negedge clk);

        // Reset in the middle of a chain.
        do_reset();
        send_word(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'b0100, 1'b0, 16'h0000, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 chk_zero("midreset");
        @(negedge clk);
        send_word(1, 16'h0001, 16'h0001, 1'b0, 1'b1, 4'b0010, 1'b0, 16'h0002, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
